// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit display scan logic.
package display_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHOW0 = 3'd1,
    GAP0  = 3'd2,
    SHOW1 = 3'd3,
    GAP1  = 3'd4
  } scan_state_t;

  localparam logic [1:0] ANODE_OFF = 2'b11;
  localparam logic [1:0] ANODE_D0  = 2'b10;
  localparam logic [1:0] ANODE_D1  = 2'b01;

endpackage

// File: rtl/display_mux_scheduler_scan_timer.sv
// Dwell counter for the scan FSM: cleared on state entry, flags when the
// selected terminal count is reached.
module scan_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] count_r;

  // Up-counter with synchronous clear; never wraps because the FSM clears it at the limit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign done = (count_r == limit);

endmodule

// File: rtl/display_mux_scheduler.sv
// Scans two hex digits through one shared seven-segment decoder, with a
// blanking gap between digits and a per-frame sample of both values.
module display_mux_scheduler
  import display_pkg::*;
#(
  parameter int DIV_CYCLES   = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [3:0] hex_sel,
  output logic [1:0] anode,
  output logic       frame_done
);

  localparam logic [CNT_W-1:0] SHOW_LIM = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit               NO_GAP   = (BLANK_CYCLES == 0);

  if ((DIV_CYCLES < 1) || (BLANK_CYCLES < 0) ||
      ((DIV_CYCLES - 1) >= (2 ** CNT_W)) ||
      ((BLANK_CYCLES > 0) && ((BLANK_CYCLES - 1) >= (2 ** CNT_W)))) begin : g_param_err
    $error("display_mux_scheduler: DIV_CYCLES must be >=1 and CNT_W must hold the dwell limits");
  end

  scan_state_t      state_r, next_state_s;
  logic [3:0]       shadow0_r, shadow1_r, shadow0_next_s, shadow1_next_s;
  logic [3:0]       hex_r, hex_next_s;
  logic [1:0]       anode_r, anode_next_s;
  logic             frame_done_r, frame_done_next_s;
  logic             clear_s, done_s;
  logic [CNT_W-1:0] limit_s;

  scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (clear_s),
    .limit (limit_s),
    .done  (done_s)
  );

  // Next-state, shadow latch and next registered output decode.
  always_comb begin
    next_state_s      = state_r;
    shadow0_next_s    = shadow0_r;
    shadow1_next_s    = shadow1_r;
    anode_next_s      = ANODE_OFF;
    hex_next_s        = 4'h0;
    frame_done_next_s = 1'b0;
    limit_s           = SHOW_LIM;

    case (state_r)
      IDLE: begin
        if (en) next_state_s = SHOW0;
        else    next_state_s = IDLE;
      end
      SHOW0: begin
        if (!en)         next_state_s = IDLE;
        else if (!done_s) next_state_s = SHOW0;
        else if (NO_GAP) next_state_s = SHOW1;
        else             next_state_s = GAP0;
      end
      GAP0: begin
        limit_s = GAP_LIM;
        if (!en)        next_state_s = IDLE;
        else if (done_s) next_state_s = SHOW1;
        else            next_state_s = GAP0;
      end
      SHOW1: begin
        if (!en)         next_state_s = IDLE;
        else if (!done_s) next_state_s = SHOW1;
        else if (NO_GAP) next_state_s = SHOW0;
        else             next_state_s = GAP1;
      end
      GAP1: begin
        limit_s = GAP_LIM;
        if (!en)        next_state_s = IDLE;
        else if (done_s) next_state_s = SHOW0;
        else            next_state_s = GAP1;
      end
      default: next_state_s = IDLE;
    endcase

    // Both digits are sampled together at frame start so one frame never tears.
    if ((next_state_s == SHOW0) && (state_r != SHOW0)) begin
      shadow0_next_s = s0;
      shadow1_next_s = s1;
    end else begin
      shadow0_next_s = shadow0_r;
      shadow1_next_s = shadow1_r;
    end

    if ((next_state_s == SHOW0) && ((state_r == GAP1) || (state_r == SHOW1))) begin
      frame_done_next_s = 1'b1;
    end else begin
      frame_done_next_s = 1'b0;
    end

    case (next_state_s)
      IDLE:    begin anode_next_s = ANODE_OFF; hex_next_s = 4'h0;           end
      SHOW0:   begin anode_next_s = ANODE_D0;  hex_next_s = shadow0_next_s; end
      GAP0:    begin anode_next_s = ANODE_OFF; hex_next_s = shadow0_next_s; end
      SHOW1:   begin anode_next_s = ANODE_D1;  hex_next_s = shadow1_next_s; end
      GAP1:    begin anode_next_s = ANODE_OFF; hex_next_s = shadow1_next_s; end
      default: begin anode_next_s = ANODE_OFF; hex_next_s = 4'h0;           end
    endcase
  end

  assign clear_s = (next_state_s != state_r) || (state_r == IDLE);

  // State, shadow and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      shadow0_r    <= 4'h0;
      shadow1_r    <= 4'h0;
      anode_r      <= ANODE_OFF;
      hex_r        <= 4'h0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      shadow0_r    <= shadow0_next_s;
      shadow1_r    <= shadow1_next_s;
      anode_r      <= anode_next_s;
      hex_r        <= hex_next_s;
      frame_done_r <= frame_done_next_s;
    end
  end

  assign hex_sel    = hex_r;
  assign anode      = anode_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_display_mux_scheduler.sv
// Scoreboard bench: directed stimulus queues hand-computed per-cycle outputs,
// a negedge monitor pops and compares them against one of two DUT instances.
module tb_display_mux_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b1;
  logic       en_b = 1'b0;
  logic [3:0] s0 = 4'h3;
  logic [3:0] s1 = 4'hA;

  logic [3:0] hex_a, hex_b;
  logic [1:0] anode_a, anode_b;
  logic       fd_a, fd_b;

  typedef struct {
    logic       sel;
    logic [1:0] anode;
    logic [3:0] hex;
    logic       fd;
    string      tag;
  } exp_t;

  exp_t  exp_q[$];
  int    total = 0;
  int    bad = 0;
  logic  cur_sel = 1'b0;
  string cur_tag = "reset";

  always #5 clk = ~clk;

  display_mux_scheduler #(.DIV_CYCLES(4), .BLANK_CYCLES(2), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .en(en), .s0(s0), .s1(s1),
    .hex_sel(hex_a), .anode(anode_a), .frame_done(fd_a)
  );

  display_mux_scheduler #(.DIV_CYCLES(4), .BLANK_CYCLES(0), .CNT_W(3)) dut_ng (
    .clk(clk), .reset(reset), .en(en_b), .s0(s0), .s1(s1),
    .hex_sel(hex_b), .anode(anode_b), .frame_done(fd_b)
  );

  // One clock edge; queue the outputs expected after it.
  task automatic step(input logic [1:0] a, input logic [3:0] h, input logic f);
    exp_t e;
    @(posedge clk);
    #1;
    e.sel = cur_sel; e.anode = a; e.hex = h; e.fd = f; e.tag = cur_tag;
    exp_q.push_back(e);
  endtask

  task automatic show(input logic [1:0] a, input logic [3:0] h, input logic f);
    step(a, h, f);
    for (int i = 0; i < 3; i++) step(a, h, 1'b0);
  endtask

  task automatic gap(input logic [3:0] h);
    step(2'b11, h, 1'b0);
    step(2'b11, h, 1'b0);
  endtask

  // Monitor: compare on every falling edge that has a pending expectation.
  initial begin
    forever begin
      exp_t       e;
      logic [1:0] ga;
      logic [3:0] gh;
      logic       gf;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.sel) begin ga = anode_b; gh = hex_b; gf = fd_b; end
        else       begin ga = anode_a; gh = hex_a; gf = fd_a; end
        total++;
        if ((ga !== e.anode) || (gh !== e.hex) || (gf !== e.fd)) begin
          bad++;
          $display("FAIL %s @%0t: got anode=%b hex=%h fd=%b, want anode=%b hex=%h fd=%b",
                   e.tag, $time, ga, gh, gf, e.anode, e.hex, e.fd);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with en=1
    step(2'b11, 4'h0, 1'b0);
    step(2'b11, 4'h0, 1'b0);
    step(2'b11, 4'h0, 1'b0);
    reset = 1'b1;

    // Normal scan: two frames, frame_done on cycle 13
    cur_tag = "scan";
    show(2'b10, 4'h3, 1'b0); gap(4'h3); show(2'b01, 4'hA, 1'b0); gap(4'hA);
    show(2'b10, 4'h3, 1'b1); gap(4'h3); show(2'b01, 4'hA, 1'b0); gap(4'hA);

    // No tearing: s0 changes during SHOW1
    cur_tag = "tearing";
    show(2'b10, 4'h3, 1'b1); gap(4'h3);
    step(2'b01, 4'hA, 1'b0);
    s0 = 4'h7;
    step(2'b01, 4'hA, 1'b0); step(2'b01, 4'hA, 1'b0); step(2'b01, 4'hA, 1'b0);
    gap(4'hA);
    show(2'b10, 4'h7, 1'b1); gap(4'h7);

    // Enable drop in SHOW1 cycle 2, then re-enable with fresh latch
    cur_tag = "en_drop";
    step(2'b01, 4'hA, 1'b0); step(2'b01, 4'hA, 1'b0);
    en = 1'b0;
    step(2'b11, 4'h0, 1'b0);
    en = 1'b1; s0 = 4'h5;
    cur_tag = "reenable";
    show(2'b10, 4'h5, 1'b0); gap(4'h5); show(2'b01, 4'hA, 1'b0); gap(4'hA);
    show(2'b10, 4'h5, 1'b1);

    // Reset during GAP0, restart like the normal scan
    cur_tag = "mid_reset";
    step(2'b11, 4'h5, 1'b0);
    reset = 1'b0;
    step(2'b11, 4'h0, 1'b0);
    step(2'b11, 4'h0, 1'b0);
    reset = 1'b1; s0 = 4'h3;
    cur_tag = "restart";
    show(2'b10, 4'h3, 1'b0); gap(4'h3); show(2'b01, 4'hA, 1'b0); gap(4'hA);
    step(2'b10, 4'h3, 1'b1);

    // No-gap instance: alternates every 4 cycles, never dark while enabled
    cur_sel = 1'b1; cur_tag = "no_gap";
    en_b = 1'b1;
    show(2'b10, 4'h3, 1'b0); show(2'b01, 4'hA, 1'b0);
    show(2'b10, 4'h3, 1'b1); show(2'b01, 4'hA, 1'b0);
    step(2'b10, 4'h3, 1'b1);
    en_b = 1'b0;
    cur_tag = "no_gap_off";
    step(2'b11, 4'h0, 1'b0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
